// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes and capture sequencer states.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } ser_state_t;

endpackage

// File: rtl/ser_capture_fsm.sv
// Sequencer for automatic WIDTH-cycle serial capture with busy/done handshake.
module ser_capture_fsm
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start_ser,
  output logic busy,
  output logic done,
  output logic shift_force
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && start_ser) begin
          state_d = S_SHIFT;
          cnt_d   = CntLast;
        end
      end
      S_SHIFT: begin
        if (en) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      // Leaves on the next edge even with en low so done is always one cycle.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign shift_force = busy;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/shift right/shift left/load) with serial capture.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic             start_ser,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_force;
  logic             idle;

  ser_capture_fsm #(
    .WIDTH(WIDTH)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .start_ser  (start_ser),
    .busy       (busy),
    .done       (done),
    .shift_force(shift_force)
  );

  assign idle = !busy && !done;

  always_comb begin
    q_d = q_q;
    if (shift_force) begin
      q_d = {ser_in_msb, q_q[WIDTH-1:1]};
    end else if (idle && !start_ser) begin
      // A start request outranks mode and leaves q untouched on that edge.
      unique case (mode_t'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {ser_in_msb, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_lsb};
        MODE_LOAD: q_d = d;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q_q <= RESET_VAL;
    else if (en) q_q <= q_d;
  end

  assign q           = q_q;
  assign qn          = ~q_q;
  assign ser_out_lsb = q_q[0];
  assign ser_out_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8, RESET_VAL=0.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       ser_in_msb;
  logic       ser_in_lsb;
  logic       start_ser;
  logic [7:0] q;
  logic [7:0] qn;
  logic       ser_out_lsb;
  logic       ser_out_msb;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .d          (d),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .start_ser  (start_ser),
    .q          (q),
    .qn         (qn),
    .ser_out_lsb(ser_out_lsb),
    .ser_out_msb(ser_out_msb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bits;
    int busy_cnt;
    int done_cnt;

    reset      = 1'b0;
    en         = 1'b1;
    mode       = 2'b00;
    d          = 8'h00;
    ser_in_msb = 1'b0;
    ser_in_lsb = 1'b0;
    start_ser  = 1'b0;

    // 1: asynchronous reset before any clock edge, then parallel load
    #2 reset = 1'b1;
    #1;
    chk("reset_q", q, 8'h00);
    chk("reset_qn", qn, 8'hFF);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    mode  = 2'b11;
    d     = 8'hA5;
    step();
    chk("load_q", q, 8'hA5);
    chk("load_qn", qn, 8'h5A);

    // 2: shift right then shift left
    mode       = 2'b01;
    ser_in_msb = 1'b1;
    step();
    chk("shr_q", q, 8'hD2);
    chk("shr_lsb", ser_out_lsb, 0);
    chk("shr_msb", ser_out_msb, 1);
    mode       = 2'b10;
    ser_in_lsb = 1'b1;
    step();
    chk("shl_q", q, 8'hA5);

    // 3: clock enable low holds everything
    mode = 2'b11;
    d    = 8'h3C;
    step();
    chk("load3c_q", q, 8'h3C);
    en = 1'b0;
    d  = 8'hFF;
    repeat (3) step();
    chk("en0_q", q, 8'h3C);
    en   = 1'b1;
    mode = 2'b00;
    step();
    chk("hold_q", q, 8'h3C);

    // 4: capture 1,0,1,1,0,0,1,0 with a 2-cycle stall mid-way
    bits      = 8'b0100_1101;
    busy_cnt  = 0;
    done_cnt  = 0;
    start_ser = 1'b1;
    step();
    start_ser = 1'b0;
    chk("cap_start_q", q, 8'h3C);
    chk("cap_start_busy", busy, 1);
    busy_cnt += int'(busy);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        en = 1'b0;
        repeat (2) begin
          step();
          busy_cnt += int'(busy);
          done_cnt += int'(done);
        end
        chk("stall_busy", busy, 1);
        en = 1'b1;
      end
      ser_in_msb = bits[i];
      step();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    chk("cap_done", done, 1);
    chk("cap_busy_end", busy, 0);
    chk("cap_q", q, 8'h4D);
    step();
    done_cnt += int'(done);
    chk("cap_done_clear", done, 0);
    chk("cap_busy_cycles", busy_cnt, 10);
    chk("cap_done_pulses", done_cnt, 1);

    // 5: reset mid-capture, then a clean full capture
    start_ser  = 1'b1;
    step();
    start_ser  = 1'b0;
    ser_in_msb = 1'b1;
    repeat (3) step();
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_q", q, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #1 reset = 1'b0;
    bits      = 8'b1001_0110;
    start_ser = 1'b1;
    step();
    start_ser = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ser_in_msb = bits[i];
      step();
      if (i < 7) chk("cap2_busy", busy, 1);
    end
    chk("cap2_done", done, 1);
    chk("cap2_q", q, 8'h96);
    step();

    // 6: start beats load; start held while busy and in DONE is ignored
    mode       = 2'b11;
    d          = 8'hFF;
    start_ser  = 1'b1;
    ser_in_msb = 1'b0;
    done_cnt   = 0;
    step();
    chk("prio_q", q, 8'h96);
    chk("prio_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      done_cnt += int'(done);
    end
    chk("held_done", done, 1);
    chk("held_q", q, 8'h00);
    step();
    chk("done_exit_busy", busy, 0);
    chk("done_exit_done", done, 0);
    start_ser = 1'b0;
    mode      = 2'b00;
    repeat (3) begin
      step();
      done_cnt += int'(done);
    end
    chk("held_done_pulses", done_cnt, 1);
    chk("held_final_q", q, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
